// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops clear on reset so a line that is low at reset release does not look like an edge.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start bit confirmed at mid-bit, data and stop sampled every full bit period.
// data/valid update only on a correctly framed byte and hold until the next accepted start bit.
module uart_rx #(
  parameter int unsigned divisor = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxi,
  output logic [7:0] data,
  output logic       valid
);

  localparam int unsigned CntW = $clog2(2 * divisor);
  localparam logic [CntW-1:0] HalfMax = CntW'(divisor - 1);
  localparam logic [CntW-1:0] FullMax = CntW'(2 * divisor - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              rx_s;
  logic              prev_q;
  logic              fall;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxi),
    .q   (rx_s)
  );

  assign fall  = prev_q & ~rx_s;
  assign data  = data_q;
  assign valid = valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      prev_q  <= rx_s;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfMax) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = StData;
            bit_d   = '0;
            valid_d = 1'b0;
          end else begin
            // Line back high at mid-start: treat as a glitch.
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == FullMax) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == FullMax) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: divisor 32 for the directed frames, divisor 8 for the byte sweep.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       rxi;
  logic       rxi2;
  logic [7:0] data;
  logic [7:0] data2;
  logic       valid;
  logic       valid2;

  int errors;
  int checks;
  int n;

  localparam int BitA = 64;
  localparam int BitB = 16;

  uart_rx #(.divisor(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxi   (rxi),
    .data  (data),
    .valid (valid)
  );

  uart_rx #(.divisor(8)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .rxi   (rxi2),
    .data  (data2),
    .valid (valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Frame is driven LSB first from a negedge; each bit lasts bitclks clocks.
  task automatic send(input logic [7:0] b, input logic stopb, input int bitclks, input bit line2);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      if (line2) rxi2 = fr[k];
      else rxi = fr[k];
      repeat (bitclks) @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    logic [7:0] partial;
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    rxi  = 1'b0;
    rxi2 = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(valid), 0);
    check("reset_data", int'(data), 8'h00);

    // Line low at release, then rises: no false start.
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rxi = 1'b1;
    repeat (10) @(negedge clk);
    check("lowrel_state", int'(dut.state_q), 0);
    check("lowrel_valid", int'(valid), 0);
    check("lowrel_data", int'(data), 8'h00);

    // 0xA5 with rise-time measurement from the start-bit edge.
    n = 0;
    fork
      send(8'hA5, 1'b1, BitA, 1'b0);
      begin
        while (!valid && n < 700) begin
          @(posedge clk);
          n++;
          #1;
        end
      end
    join
    check("a5_rise", (n >= 609 && n <= 611) ? 610 : n, 610);
    check("a5_valid", int'(valid), 1);
    check("a5_data", int'(data), 8'hA5);
    @(negedge clk);
    check("a5_valid_hold", int'(valid), 1);

    // Short low glitch: back to idle, outputs untouched.
    rxi = 1'b0;
    repeat (10) @(negedge clk);
    rxi = 1'b1;
    repeat (54) @(negedge clk);
    check("glitch_state", int'(dut.state_q), 0);
    check("glitch_valid", int'(valid), 1);
    check("glitch_data", int'(data), 8'hA5);

    // Framing error, then a good frame after a fresh edge.
    send(8'h3C, 1'b0, BitA, 1'b0);
    check("ferr_valid", int'(valid), 0);
    check("ferr_data", int'(data), 8'hA5);
    rxi = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h5A, 1'b1, BitA, 1'b0);
    check("5a_valid", int'(valid), 1);
    check("5a_data", int'(data), 8'h5A);

    // Reset in the middle of data bit 4.
    partial = 8'h0F;
    rxi = 1'b0;
    repeat (BitA) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rxi = partial[k];
      repeat (BitA) @(negedge clk);
    end
    rxi = partial[4];
    repeat (BitA / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", int'(valid), 0);
    check("midrst_data", int'(data), 8'h00);
    repeat (3) @(negedge clk);
    rxi = 1'b1;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("postrst_valid", int'(valid), 0);
    check("postrst_state", int'(dut.state_q), 0);
    send(8'h81, 1'b1, BitA, 1'b0);
    check("81_valid", int'(valid), 1);
    check("81_data", int'(data), 8'h81);

    // All byte values back to back on the faster instance.
    for (int i = 0; i < 256; i++) begin
      send(i[7:0], 1'b1, BitB, 1'b1);
      check("sweep_valid", int'(valid2), 1);
      check("sweep_data", int'(data2), i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
